// File: rtl/bus_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ requesters onto one request/response bus.
// Optional abort-on-stall watchdog is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          bus_valid_o,
    output logic [DATA_WIDTH-1:0]         bus_data_o,
    input  logic                          bus_ready_i,
    input  logic                          bus_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]         bus_rsp_data_i,
    output logic                          busy_o,
    output logic [$clog2(NUM_REQ)-1:0]    owner_o,
    output logic                          timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W:0]   cand;
    logic             found;

    // Scan requesters starting at the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req_valid_i[cand[IDX_W-1:0]]) begin
                winner = cand[IDX_W-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (rst_n && state == IDLE && found) begin
            req_ready_o = NUM_REQ'(1) << winner;
        end
    end

    assign next_ptr = (owner_o == IDX_W'(NUM_REQ - 1)) ? '0 : owner_o + 1'b1;
    assign busy_o   = (state != IDLE);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    assign cnt_done = (cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            owner_o     <= '0;
            bus_valid_o <= 1'b0;
            bus_data_o  <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt         <= '0;
            timeout_o   <= 1'b0;
`endif
        end else begin
            rsp_valid_o <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            timeout_o   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        owner_o     <= winner;
                        bus_data_o  <= req_data_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        bus_valid_o <= 1'b1;
                        state       <= REQ;
`ifdef BUS_ARB_TIMEOUT_EN
                        cnt         <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus_ready_i) begin
                        bus_valid_o <= 1'b0;
                        state       <= RSP;
`ifdef BUS_ARB_TIMEOUT_EN
                        cnt         <= '0;
                    end else if (cnt_done) begin
                        bus_valid_o <= 1'b0;
                        rsp_valid_o <= NUM_REQ'(1) << owner_o;
                        rsp_data_o  <= '1;
                        timeout_o   <= 1'b1;
                        ptr         <= next_ptr;
                        state       <= IDLE;
                    end else begin
                        cnt         <= cnt + 1'b1;
`endif
                    end
                end
                // A response completes the transaction; the owner's reply is a one-cycle pulse.
                RSP: begin
                    if (bus_rsp_valid_i) begin
                        rsp_valid_o <= NUM_REQ'(1) << owner_o;
                        rsp_data_o  <= bus_rsp_data_i;
                        ptr         <= next_ptr;
                        state       <= IDLE;
`ifdef BUS_ARB_TIMEOUT_EN
                    end else if (cnt_done) begin
                        rsp_valid_o <= NUM_REQ'(1) << owner_o;
                        rsp_data_o  <= '1;
                        timeout_o   <= 1'b1;
                        ptr         <= next_ptr;
                        state       <= IDLE;
                    end else begin
                        cnt         <= cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (default build): table-driven round-robin
// transactions plus hand-written latency, reset and stall sequences.
module tb_bus_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req_valid_i;
    logic [4*DW-1:0]  req_data_i;
    logic [3:0]       req_ready_o;
    logic [3:0]       rsp_valid_o;
    logic [DW-1:0]    rsp_data_o;
    logic             bus_valid_o;
    logic [DW-1:0]    bus_data_o;
    logic             bus_ready_i;
    logic             bus_rsp_valid_i;
    logic [DW-1:0]    bus_rsp_data_i;
    logic             busy_o;
    logic [1:0]       owner_o;
    logic             timeout_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        int         grant;
        int         readyDelay;
    } vec_t;

    vec_t vectors[12];

    bus_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_data_o      (rsp_data_o),
        .bus_valid_o     (bus_valid_o),
        .bus_data_o      (bus_data_o),
        .bus_ready_i     (bus_ready_i),
        .bus_rsp_valid_i (bus_rsp_valid_i),
        .bus_rsp_data_i  (bus_rsp_data_i),
        .busy_o          (busy_o),
        .owner_o         (owner_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oneHot(input int i);
        oneHot = 4'b0001 << i;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // One full transaction, entered at a negedge with the arbiter idle; returns at
    // the negedge where the response pulse is visible so the next accept overlaps it.
    task automatic applyStimulus(input vec_t v, input int n);
        logic [31:0] rspWord;
        logic [31:0] reqWord;
        rspWord = 32'h5000_0000 + 32'(n);
        reqWord = 32'hC000_0000 + 32'(n << 8) + 32'(v.grant);
        for (int i = 0; i < 4; i++) begin
            req_data_i[i*DW +: DW] = 32'hC000_0000 + 32'(n << 8) + 32'(i);
        end
        req_valid_i = v.req;
        #1;
        checkOutput($sformatf("v%0d req_ready", n), 32'(req_ready_o), 32'(oneHot(v.grant)));
        @(negedge clk);
        req_valid_i = '0;
        req_data_i  = '1;
        checkOutput($sformatf("v%0d bus_valid", n), 32'(bus_valid_o), 32'd1);
        checkOutput($sformatf("v%0d bus_data", n), bus_data_o, reqWord);
        checkOutput($sformatf("v%0d owner", n), 32'(owner_o), 32'(v.grant));
        repeat (v.readyDelay) @(negedge clk);
        checkOutput($sformatf("v%0d bus_data_held", n), bus_data_o, reqWord);
        bus_ready_i     = 1'b1;
        bus_rsp_valid_i = 1'b1;
        bus_rsp_data_i  = 32'hBAD0_0000;
        @(negedge clk);
        bus_ready_i     = 1'b0;
        bus_rsp_valid_i = 1'b0;
        checkOutput($sformatf("v%0d bus_valid_drop", n), 32'(bus_valid_o), 32'd0);
        checkOutput($sformatf("v%0d no_early_rsp", n), 32'(rsp_valid_o), 32'd0);
        bus_rsp_valid_i = 1'b1;
        bus_rsp_data_i  = rspWord;
        @(negedge clk);
        bus_rsp_valid_i = 1'b0;
        checkOutput($sformatf("v%0d rsp_valid", n), 32'(rsp_valid_o), 32'(oneHot(v.grant)));
        checkOutput($sformatf("v%0d rsp_data", n), rsp_data_o, rspWord);
        checkOutput($sformatf("v%0d busy_idle", n), 32'(busy_o), 32'd0);
    endtask

    initial begin
        vectors[0]  = '{4'b1111, 0, 0};
        vectors[1]  = '{4'b1111, 1, 1};
        vectors[2]  = '{4'b1111, 2, 0};
        vectors[3]  = '{4'b1111, 3, 2};
        vectors[4]  = '{4'b1111, 0, 0};
        vectors[5]  = '{4'b0001, 0, 1};
        vectors[6]  = '{4'b0100, 2, 0};
        vectors[7]  = '{4'b1001, 3, 0};
        vectors[8]  = '{4'b1001, 0, 1};
        vectors[9]  = '{4'b1001, 3, 0};
        vectors[10] = '{4'b0110, 1, 0};
        vectors[11] = '{4'b0010, 1, 2};

        rst_n           = 1'b0;
        req_valid_i     = 4'b1111;
        req_data_i      = '0;
        bus_ready_i     = 1'b0;
        bus_rsp_valid_i = 1'b0;
        bus_rsp_data_i  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset req_ready", 32'(req_ready_o), 32'd0);
        checkOutput("reset bus_valid", 32'(bus_valid_o), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("reset busy", 32'(busy_o), 32'd0);
        checkOutput("reset timeout", 32'(timeout_o), 32'd0);
        checkOutput("reset owner", 32'(owner_o), 32'd0);
        checkOutput("reset bus_data", bus_data_o, 32'd0);
        checkOutput("reset rsp_data", rsp_data_o, 32'd0);

        req_valid_i = '0;
        rst_n       = 1'b1;
        @(negedge clk);
        checkOutput("idle no_req ready", 32'(req_ready_o), 32'd0);
        checkOutput("idle no_req busy", 32'(busy_o), 32'd0);

        for (int n = 0; n < 12; n++) begin
            applyStimulus(vectors[n], n);
        end

        // Exact-cycle latency sequence; the pointer is at 2 here and 0100 wins regardless.
        req_data_i            = '0;
        req_data_i[2*DW +: DW] = 32'hDEADBEEF;
        req_valid_i           = 4'b0100;
        #1;
        checkOutput("lat cyc0 ready", 32'(req_ready_o), 32'h4);
        @(negedge clk);
        req_valid_i = '0;
        checkOutput("lat cyc1 bus_valid", 32'(bus_valid_o), 32'd1);
        checkOutput("lat cyc1 bus_data", bus_data_o, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("lat cyc2 bus_valid", 32'(bus_valid_o), 32'd1);
        @(negedge clk);
        checkOutput("lat cyc3 bus_valid", 32'(bus_valid_o), 32'd1);
        bus_ready_i = 1'b1;
        @(negedge clk);
        bus_ready_i = 1'b0;
        checkOutput("lat cyc4 bus_valid", 32'(bus_valid_o), 32'd0);
        checkOutput("lat cyc4 busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        checkOutput("lat cyc5 rsp_valid", 32'(rsp_valid_o), 32'd0);
        bus_rsp_valid_i = 1'b1;
        bus_rsp_data_i  = 32'h1234;
        @(negedge clk);
        bus_rsp_valid_i = 1'b0;
        checkOutput("lat cyc6 rsp_valid", 32'(rsp_valid_o), 32'h4);
        checkOutput("lat cyc6 rsp_data", rsp_data_o, 32'h1234);
        @(negedge clk);
        checkOutput("lat cyc7 rsp_pulse", 32'(rsp_valid_o), 32'd0);

        // Reset while waiting in RSP: the pending response is dropped and the pointer returns to 0.
        req_valid_i = 4'b0100;
        @(negedge clk);
        req_valid_i = '0;
        bus_ready_i = 1'b1;
        @(negedge clk);
        bus_ready_i     = 1'b0;
        req_valid_i     = 4'b1111;
        bus_rsp_valid_i = 1'b1;
        bus_rsp_data_i  = 32'h7777;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst busy", 32'(busy_o), 32'd0);
        checkOutput("midrst ready", 32'(req_ready_o), 32'd0);
        checkOutput("midrst bus_valid", 32'(bus_valid_o), 32'd0);
        checkOutput("midrst rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("midrst timeout", 32'(timeout_o), 32'd0);
        checkOutput("midrst owner", 32'(owner_o), 32'd0);
        @(negedge clk);
        req_valid_i = '0;
        rst_n       = 1'b1;
        @(negedge clk);
        checkOutput("postrst rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("postrst busy", 32'(busy_o), 32'd0);
        bus_rsp_valid_i = 1'b0;
        req_valid_i     = 4'b0011;
        #1;
        checkOutput("postrst grant", 32'(req_ready_o), 32'h1);

        // Bus never accepts: without the watchdog the arbiter must keep waiting.
        @(negedge clk);
        req_valid_i = '0;
        checkOutput("postrst owner", 32'(owner_o), 32'd0);
        repeat (100) @(negedge clk);
        checkOutput("stall busy", 32'(busy_o), 32'd1);
        checkOutput("stall bus_valid", 32'(bus_valid_o), 32'd1);
        checkOutput("stall timeout", 32'(timeout_o), 32'd0);
        checkOutput("stall rsp_valid", 32'(rsp_valid_o), 32'd0);
        bus_ready_i = 1'b1;
        @(negedge clk);
        bus_ready_i     = 1'b0;
        bus_rsp_valid_i = 1'b1;
        bus_rsp_data_i  = 32'hCAFE0001;
        @(negedge clk);
        bus_rsp_valid_i = 1'b0;
        checkOutput("stall rsp_valid_end", 32'(rsp_valid_o), 32'h1);
        checkOutput("stall rsp_data_end", rsp_data_o, 32'hCAFE0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
